// File: rtl/cfg_stream_pkg.sv
// Shared types for the configuration bit streamer: FSM states, FIFO entry layout, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cfg_stream_pkg;

    // Width of one configuration word. The FIFO entry layout below is built on it,
    // so the streamer's WORD_W parameter must stay equal to this value.
    localparam int CFG_WORD_W   = 32;
    // Holds a bit count of 0..CFG_WORD_W inclusive.
    localparam int CFG_LBITS_W  = $clog2(CFG_WORD_W) + 1;
    // Width of the optional accepted-bit counter.
    localparam int CFG_BITCNT_W = 32;

    // Bits needed for a counter that must reach max_val.
    function automatic int cfg_cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISHED  = 3'd4,
        ST_ERR       = 3'd5
    } cfg_state_e;

    typedef struct packed {
        logic                   last;
        logic [CFG_LBITS_W-1:0] last_bits;
        logic [CFG_WORD_W-1:0]  data;
    } cfg_entry_t;

endpackage

// File: rtl/cfg_word_fifo.sv
// Generic synchronous FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
// Latency: a pushed entry is visible at o_pop_dat the cycle after the push.
// Backpressure: o_full refuses pushes, except a push is taken when a pop frees an entry in the same cycle.
//
// Ports: i_clk, i_rst_n (synchronous, active-low), i_clr (flush), i_push/i_push_dat,
//        i_pop/o_pop_dat (head entry, valid while !o_empty), o_full, o_empty.
module cfg_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                       (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_pop_dat = r_mem[r_rd_ptr[PTR_W-2:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clr) r_mem[r_wr_ptr[PTR_W-2:0]] <= i_push_dat;
    end

endmodule

// File: rtl/config_bit_streamer.sv
// Buffers 32-bit config words and streams them LSB-first on a 1-bit valid/ready port, then awaits cfg_done.
// Latency: first bit presented 2 cycles after the first accepted word; one bit per cycle thereafter, no bubble between words.
// Backpressure: cfg_ready low holds cfg_bits stable; in_ready drops when the word FIFO is full or after the last word.
//
// Ports: clock, reset (synchronous, active-low), start (arm pulse);
//        word input in_valid/in_ready/in_data/in_last/in_last_bits;
//        serial output cfg_valid/cfg_ready/cfg_bits; cfg_done from the accelerator;
//        status busy/done/error.
// Optional: define CFG_BITCOUNT_EN to add output bit_count[31:0] (accepted bits since start, saturating).
module config_bit_streamer
    import cfg_stream_pkg::*;
#(
    parameter int WORD_W       = CFG_WORD_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic [$clog2(WORD_W):0]   in_last_bits,
    output logic                      cfg_valid,
    input  logic                      cfg_ready,
    output logic                      cfg_bits,
    input  logic                      cfg_done,
    output logic                      busy,
    output logic                      done,
    output logic                      error
`ifdef CFG_BITCOUNT_EN
    ,
    output logic [CFG_BITCNT_W-1:0]   bit_count
`endif
);

    localparam int LB_W  = $clog2(WORD_W) + 1;
    localparam int TMR_W = cfg_cnt_w(DONE_TIMEOUT);

    cfg_state_e        r_state;
    cfg_state_e        w_state_nxt;
    logic [WORD_W-1:0] r_shreg;
    logic [LB_W-1:0]   r_bits_left;
    logic              r_cur_last;
    logic              r_last_seen;
    logic [TMR_W-1:0]  r_timer;

    cfg_entry_t        w_push_ent;
    cfg_entry_t        w_pop_ent;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_bad_last;

    // ---------------------------------------------------------------- word FIFO
    assign w_push_ent.last      = in_last;
    assign w_push_ent.last_bits = in_last_bits;
    assign w_push_ent.data      = in_data;

    cfg_word_fifo #(
        .WIDTH ($bits(cfg_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_clr      (w_flush),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_pop_dat  (w_pop_ent),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // ---------------------------------------------------------------- outputs
    // Once the last word is in, further words belong to no bitstream and are refused.
    assign in_ready   = ((r_state == ST_ARMED) || (r_state == ST_SHIFT)) && !w_full && !r_last_seen;
    assign cfg_valid  = (r_state == ST_SHIFT);
    assign cfg_bits   = cfg_valid && r_shreg[0];
    assign busy       = (r_state == ST_ARMED) || (r_state == ST_SHIFT) || (r_state == ST_WAIT_DONE);
    // FINISHED and ERR are only left through start or reset, so the states themselves are the sticky flags.
    assign done       = (r_state == ST_FINISHED);
    assign error      = (r_state == ST_ERR);

    assign w_push     = in_valid && in_ready;
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_bad_last = w_push && in_last &&
                        ((in_last_bits == '0) || (in_last_bits > LB_W'(WORD_W)));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARMED;
                    w_flush     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (cfg_done || w_bad_last) begin
                    w_state_nxt = ST_ERR;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cfg_done || w_bad_last) begin
                    w_state_nxt = ST_ERR;
                end else if (w_accept && (r_bits_left == LB_W'(1))) begin
                    if (r_cur_last) begin
                        w_state_nxt = ST_WAIT_DONE;
                    end else if (!w_empty) begin
                        // Reload in the same cycle as the final bit so words run back to back.
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (cfg_done) begin
                    w_state_nxt = ST_FINISHED;
                end else if (r_timer == TMR_W'(DONE_TIMEOUT - 1)) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_FINISHED, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_ARMED;
                    w_flush     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- shifter and timers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_cur_last  <= 1'b0;
            r_last_seen <= 1'b0;
            r_timer     <= '0;
        end else begin
            if (w_pop) begin
                r_shreg     <= w_pop_ent.data;
                r_bits_left <= w_pop_ent.last ? w_pop_ent.last_bits : LB_W'(WORD_W);
                r_cur_last  <= w_pop_ent.last;
            end else if (w_accept) begin
                r_shreg     <= r_shreg >> 1;
                r_bits_left <= r_bits_left - LB_W'(1);
            end

            // Counts cycles spent in WAIT_DONE; zero on the first cycle there.
            r_timer <= (r_state == ST_WAIT_DONE) ? r_timer + TMR_W'(1) : '0;

            if (w_flush) begin
                r_last_seen <= 1'b0;
            end else if (w_push && in_last) begin
                r_last_seen <= 1'b1;
            end
        end
    end

`ifdef CFG_BITCOUNT_EN
    logic [CFG_BITCNT_W-1:0] r_bit_count;

    always_ff @(posedge clock) begin
        if (!reset || w_flush) begin
            r_bit_count <= '0;
        end else if (w_accept && (r_bit_count != '1)) begin
            r_bit_count <= r_bit_count + CFG_BITCNT_W'(1);
        end
    end

    assign bit_count = r_bit_count;
`else
    // Accepted-bit counter not built in this configuration.
`endif

endmodule

// File: tb/tb_config_bit_streamer.sv
// Self-checking bench for config_bit_streamer: scoreboard of expected serial bits plus directed status checks.
// Latency: n/a.
// Backpressure: cfg_ready is driven in always-high, toggling, random or held-low modes.
module tb_config_bit_streamer;

    localparam int DONE_TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [5:0]  in_last_bits = '0;
    logic        cfg_valid;
    logic        cfg_ready = 1'b0;
    logic        cfg_bits;
    logic        cfg_done = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
`ifdef CFG_BITCOUNT_EN
    logic [31:0] bit_count;
`endif

    config_bit_streamer #(
        .WORD_W       (32),
        .FIFO_DEPTH   (4),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_last_bits (in_last_bits),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_bits     (cfg_bits),
        .cfg_done     (cfg_done),
        .busy         (busy),
        .done         (done),
        .error        (error)
`ifdef CFG_BITCOUNT_EN
        ,
        .bit_count    (bit_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit b;
        bit fin;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int fin_cyc   = 0;
    int bits_acc  = 0;
    int words_acc = 0;
    int rdy_mode  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word contributes its low n bits, LSB first, n = 32 or in_last_bits.
    task automatic push_model(input logic [31:0] d, input logic last, input logic [5:0] lb);
        int n;
        n = last ? int'(lb) : 32;
        if (last && (lb == 0 || lb > 32)) return;
        for (int i = 0; i < n; i++) begin
            exp_bit_t e;
            e.b   = d[i];
            e.fin = last && (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // cfg_ready driver: 0 always high, 1 toggle, 2 random, 3 held low.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       cfg_ready = 1'b1;
                1:       cfg_ready = ~cfg_ready;
                2:       cfg_ready = 1'($urandom_range(0, 1));
                default: cfg_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every presented bit must match the scoreboard head (this also covers stall stability).
    initial begin
        forever begin
            @(negedge clock);
            if (cfg_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", cfg_valid, 0);
                end else begin
                    chk("cfg_bits", cfg_bits, exp_q[0].b);
                    if (cfg_ready) begin
                        if (exp_q[0].fin) fin_cyc = cyc + 1;
                        exp_q.delete(0);
                        bits_acc++;
                    end
                end
            end
        end
    end

    // All tasks below start and end at posedge + 1.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [5:0] lb);
        bit acc;
        acc          = 0;
        in_valid     = 1'b1;
        in_data      = d;
        in_last      = last;
        in_last_bits = lb;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1;
                words_acc++;
                push_model(d, last, lb);
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) chk("send_timeout", in_ready, 1);
    endtask

    task automatic do_start();
        start    = 1'b1;
        bits_acc = 0;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 4000 && exp_q.size() != 0; n++) @(negedge clock);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic finish_stream(input int gap);
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        cfg_done = 1'b1;
        @(posedge clock);
        #1;
        cfg_done = 1'b0;
        @(negedge clock);
        chk("done_set", done, 1);
        chk("done_busy", busy, 0);
        chk("done_error", error, 0);
`ifdef CFG_BITCOUNT_EN
        chk("bit_count", bit_count, bits_acc);
`endif
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        // ---- reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_cfg_bits", cfg_bits, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // ---- single word 0xA5, 8 bits, with 2-cycle first-bit latency
        rdy_mode = 0;
        do_start();
        send_word(32'hA5, 1'b1, 6'd8);
        @(negedge clock);
        chk("lat_load_cycle", cfg_valid, 0);
        @(negedge clock);
        chk("lat_first_bit", cfg_valid, 1);
        @(posedge clock);
        #1;
        wait_drain();
        finish_stream(3);

        // ---- back-to-back words, no bubble
        do_start();
        send_word(32'hFFFF_FFFF, 1'b0, 6'd0);
        send_word(32'h0000_0001, 1'b1, 6'd32);
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (cfg_valid) break;
        end
        v = 0;
        for (int k = 0; k < 64; k++) begin
            if (cfg_valid) v++;
            @(negedge clock);
        end
        chk("no_bubble", v, 64);
        chk("valid_drop_after_last", cfg_valid, 0);
        @(posedge clock);
        #1;
        wait_drain();
        finish_stream(1);

        // ---- toggling backpressure on 0x3C
        rdy_mode = 1;
        do_start();
        send_word(32'h3C, 1'b1, 6'd8);
        wait_drain();
`ifdef CFG_BITCOUNT_EN
        chk("bitcount_3c", bit_count, 8);
`endif
        finish_stream(2);

        // ---- FIFO full: shifter holds one word, FIFO four more
        rdy_mode  = 3;
        do_start();
        words_acc = 0;
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 6'd0);
        @(negedge clock);
        chk("full_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        fork
            send_word($urandom, 1'b1, 6'($urandom_range(1, 32)));
            begin
                repeat (10) @(negedge clock);
                chk("full_hold_words", words_acc, 5);
                rdy_mode = 0;
            end
        join
        wait_drain();
        finish_stream(0);

        // ---- done timeout, then start clears error
        rdy_mode = 2;
        do_start();
        send_word($urandom, 1'b0, 6'd0);
        send_word($urandom, 1'b1, 6'($urandom_range(1, 32)));
        wait_drain();
        for (int n = 0; n < DONE_TIMEOUT + 100; n++) begin
            @(negedge clock);
            if (error) break;
        end
        chk("timeout_error", error, 1);
        chk("timeout_cycles", cyc - fin_cyc, DONE_TIMEOUT);
        @(posedge clock);
        #1;
        do_start();
        @(negedge clock);
        chk("restart_error_clr", error, 0);
        chk("restart_busy", busy, 1);
        @(posedge clock);
        #1;

        // ---- reset mid-shift (streamer is ARMED from the restart above)
        rdy_mode = 0;
        send_word($urandom, 1'b1, 6'd32);
        for (int n = 0; n < 100 && bits_acc < 4; n++) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        exp_q.delete();
        @(negedge clock);
        chk("midrst_cfg_valid", cfg_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        do_start();
        send_word(32'h5A5A_1234, 1'b1, 6'd20);
        wait_drain();
        finish_stream(1);

        // ---- faults: bad last_bits, premature cfg_done
        do_start();
        send_word($urandom, 1'b1, 6'd0);
        @(negedge clock);
        chk("bad_last_bits_err", error, 1);
        @(posedge clock);
        #1;
        do_start();
        cfg_done = 1'b1;
        @(posedge clock);
        #1;
        cfg_done = 1'b0;
        @(negedge clock);
        chk("premature_done_err", error, 1);
        chk("premature_done_flag", done, 0);
        @(posedge clock);
        #1;

        // ---- randomized bitstreams under random backpressure
        for (int r = 0; r < 12; r++) begin
            int nw;
            rdy_mode = 2;
            do_start();
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
                send_word($urandom, (w == nw - 1), 6'($urandom_range(1, 32)));
            end
            wait_drain();
            finish_stream($urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
